// File: rtl/settable_clock_hms.sv
`default_nettype none
// ============================================================================
//  Module      : settable_clock_hms
//  Description : 24-hour HH:MM:SS clock with a shadow-copy set FSM, external
//                load port, blinking edit field and 12h/24h BCD display.
//                Optional macro SETCLK_TIMEOUT_EN: set mode auto-exits after
//                SET_TIMEOUT_S idle seconds.
//  Revision    : 1.0 - initial release
// ============================================================================
module settable_clock_hms #(
    parameter int TICK_DIV      = 50000000,
    parameter int BLINK_DIV     = 25000000,
    parameter int SET_TIMEOUT_S = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_enable,
    input  logic        mode24,
    input  logic        pulsed_set,
    input  logic        pulsed_up,
    input  logic        pulsed_down,
    input  logic        ext_load,
    input  logic [4:0]  ext_hours,
    input  logic [5:0]  ext_minutes,
    output logic [23:0] digits,
    output logic [5:0]  blank,
    output logic        is_pm,
    output logic [1:0]  cur_state,
    output logic        propagate,
    output logic [4:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds
);
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HR  = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;
    localparam logic [1:0] ST_SET_SEC = 2'd3;

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [PRE_W-1:0] prescaler;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;
    logic [4:0]       sh_hours,   sh_hours_n;
    logic [5:0]       sh_minutes, sh_minutes_n;
    logic [5:0]       sh_seconds, sh_seconds_n;

    logic tick, in_set, set_acc, up_acc, down_acc;
    logic load_ok, commit, timeout, step_up, step_down;

    assign tick      = (prescaler == PRE_LAST);
    assign in_set    = (state != ST_RUN);
    assign set_acc   = pulsed_set & set_enable;
    assign up_acc    = pulsed_up & set_enable;
    assign down_acc  = pulsed_down & set_enable;
    assign load_ok   = ext_load && !in_set && (ext_hours <= 5'd23) && (ext_minutes <= 6'd59);
    assign commit    = set_acc && (state == ST_SET_SEC);
    assign step_up   = in_set && up_acc && !down_acc && !set_acc;
    assign step_down = in_set && down_acc && !up_acc && !set_acc;
    assign cur_state = state;

`ifdef SETCLK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(SET_TIMEOUT_S + 2);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(SET_TIMEOUT_S);
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || !in_set || set_acc || up_acc || down_acc) begin
            idle_cnt <= '0;
        end else if (tick && (idle_cnt != IDLE_LIMIT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = in_set && (idle_cnt == IDLE_LIMIT);
`else
    logic [31:0] unused_set_timeout;
    assign unused_set_timeout = SET_TIMEOUT_S;
    assign timeout = 1'b0;
`endif

    // An explicit set pulse takes precedence over an idle timeout.
    always_comb begin
        state_next = state;
        if (set_acc) begin
            case (state)
                ST_RUN:     state_next = ST_SET_HR;
                ST_SET_HR:  state_next = ST_SET_MIN;
                ST_SET_MIN: state_next = ST_SET_SEC;
                default:    state_next = ST_RUN;
            endcase
        end else if (timeout) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        sh_hours_n   = sh_hours;
        sh_minutes_n = sh_minutes;
        sh_seconds_n = sh_seconds;
        if ((state == ST_RUN) && set_acc) begin
            if (load_ok) begin
                sh_hours_n   = ext_hours;
                sh_minutes_n = ext_minutes;
                sh_seconds_n = '0;
            end else begin
                sh_hours_n   = hours;
                sh_minutes_n = minutes;
                sh_seconds_n = seconds;
            end
        end else if (step_up || step_down) begin
            case (state)
                ST_SET_HR: begin
                    if (step_up) sh_hours_n = (sh_hours == 5'd23) ? 5'd0 : sh_hours + 5'd1;
                    else         sh_hours_n = (sh_hours == 5'd0) ? 5'd23 : sh_hours - 5'd1;
                end
                ST_SET_MIN: begin
                    if (step_up) sh_minutes_n = (sh_minutes == 6'd59) ? 6'd0 : sh_minutes + 6'd1;
                    else         sh_minutes_n = (sh_minutes == 6'd0) ? 6'd59 : sh_minutes - 6'd1;
                end
                ST_SET_SEC: begin
                    if (step_up) sh_seconds_n = (sh_seconds == 6'd59) ? 6'd0 : sh_seconds + 6'd1;
                    else         sh_seconds_n = (sh_seconds == 6'd0) ? 6'd59 : sh_seconds - 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            propagate   <= 1'b0;
            prescaler   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            hours       <= '0;
            minutes     <= '0;
            seconds     <= '0;
            sh_hours    <= '0;
            sh_minutes  <= '0;
            sh_seconds  <= '0;
        end else begin
            state      <= state_next;
            propagate  <= commit;
            sh_hours   <= sh_hours_n;
            sh_minutes <= sh_minutes_n;
            sh_seconds <= sh_seconds_n;

            if (commit) begin
                hours     <= sh_hours;
                minutes   <= sh_minutes;
                seconds   <= sh_seconds;
                prescaler <= '0;
            end else if (load_ok) begin
                hours     <= ext_hours;
                minutes   <= ext_minutes;
                seconds   <= '0;
                prescaler <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick) begin
                    if (seconds == 6'd59) begin
                        seconds <= '0;
                        if (minutes == 6'd59) begin
                            minutes <= '0;
                            hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                        end else begin
                            minutes <= minutes + 6'd1;
                        end
                    end else begin
                        seconds <= seconds + 6'd1;
                    end
                end
            end

            // Phase restarts with the counter so a newly selected field is visible at once.
            if (state_next != state) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    logic [4:0] src_h, disp_h;
    logic [5:0] src_m, src_s;
    logic [7:0] hr_bcd, min_bcd, sec_bcd;

    always_comb begin
        src_h  = in_set ? sh_hours   : hours;
        src_m  = in_set ? sh_minutes : minutes;
        src_s  = in_set ? sh_seconds : seconds;
        disp_h = src_h;
        if (!mode24) begin
            if (src_h == 5'd0)       disp_h = 5'd12;
            else if (src_h > 5'd12)  disp_h = src_h - 5'd12;
        end
        is_pm   = (src_h >= 5'd12);
        hr_bcd  = to_bcd({1'b0, disp_h});
        min_bcd = to_bcd(src_m);
        sec_bcd = to_bcd(src_s);
        digits  = {hr_bcd, min_bcd, sec_bcd};
        blank   = '0;
        blank[5] = !mode24 && (hr_bcd[7:4] == 4'd0);
        if (in_set && blink_phase) begin
            case (state)
                ST_SET_HR:  blank[5:4] = 2'b11;
                ST_SET_MIN: blank[3:2] = 2'b11;
                ST_SET_SEC: blank[1:0] = 2'b11;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_settable_clock_hms.sv
`default_nettype none
// Self-checking bench for settable_clock_hms (TICK_DIV=4, BLINK_DIV=32, SET_TIMEOUT_S=3).
module tb_settable_clock_hms;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_enable = 1'b1;
    logic        mode24 = 1'b0;
    logic        pulsed_set = 1'b0, pulsed_up = 1'b0, pulsed_down = 1'b0, ext_load = 1'b0;
    logic [4:0]  ext_hours = '0;
    logic [5:0]  ext_minutes = '0;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic        is_pm;
    logic [1:0]  cur_state;
    logic        propagate;
    logic [4:0]  hours;
    logic [5:0]  minutes, seconds;

    settable_clock_hms #(.TICK_DIV(4), .BLINK_DIV(32), .SET_TIMEOUT_S(3)) dut (
        .clk(clk), .reset(reset), .set_enable(set_enable), .mode24(mode24),
        .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
        .ext_load(ext_load), .ext_hours(ext_hours), .ext_minutes(ext_minutes),
        .digits(digits), .blank(blank), .is_pm(is_pm), .cur_state(cur_state),
        .propagate(propagate), .hours(hours), .minutes(minutes), .seconds(seconds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] dig;
        logic [5:0]  blk;
        logic        pm;
        logic [1:0]  st;
        logic        chk_live;
        logic [4:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
    } exp_t;

    typedef struct {
        logic        m24;
        logic [4:0]  eh;
        logic [5:0]  em;
        logic [23:0] dig;
        logic [5:0]  blk;
        logic        pm;
        logic [4:0]  h;
        logic [5:0]  m;
    } load_vec_t;

    exp_t      sb[$];
    load_vec_t tbl[10];
    int        checks = 0;
    int        failures = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic u, input logic d, input logic l,
                         input logic [4:0] eh, input logic [5:0] em);
        pulsed_set = s; pulsed_up = u; pulsed_down = d; ext_load = l;
        ext_hours = eh; ext_minutes = em;
        cyc(1);
        pulsed_set = 1'b0; pulsed_up = 1'b0; pulsed_down = 1'b0; ext_load = 1'b0;
    endtask

    task automatic exp_push(input logic [23:0] dig, input logic [5:0] blk, input logic pm,
                            input logic [1:0] st, input logic chk, input logic [4:0] h,
                            input logic [5:0] m, input logic [5:0] s);
        exp_t e;
        e.dig = dig; e.blk = blk; e.pm = pm; e.st = st;
        e.chk_live = chk; e.h = h; e.m = m; e.s = s;
        sb.push_back(e);
    endtask

    task automatic compare(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (digits !== e.dig || blank !== e.blk || is_pm !== e.pm || cur_state !== e.st ||
            (e.chk_live && (hours !== e.h || minutes !== e.m || seconds !== e.s))) begin
            failures++;
            $display("FAIL %s: got digits=%h blank=%b pm=%b st=%0d live=%0d:%0d:%0d, want digits=%h blank=%b pm=%b st=%0d live=%0d:%0d:%0d (live checked=%0d)",
                     name, digits, blank, is_pm, cur_state, hours, minutes, seconds,
                     e.dig, e.blk, e.pm, e.st, e.h, e.m, e.s, e.chk_live);
        end
    endtask

    task automatic check_prop(input string name, input logic want);
        checks++;
        if (propagate !== want) begin
            failures++;
            $display("FAIL %s: propagate got %b want %b", name, propagate, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 5'd23, 6'd59, 24'h115900, 6'b000000, 1'b1, 5'd23, 6'd59};
        tbl[1] = '{1'b0, 5'd0,  6'd5,  24'h120500, 6'b000000, 1'b0, 5'd0,  6'd5};
        tbl[2] = '{1'b1, 5'd0,  6'd5,  24'h000500, 6'b000000, 1'b0, 5'd0,  6'd5};
        tbl[3] = '{1'b0, 5'd9,  6'd0,  24'h090000, 6'b100000, 1'b0, 5'd9,  6'd0};
        tbl[4] = '{1'b0, 5'd12, 6'd30, 24'h123000, 6'b000000, 1'b1, 5'd12, 6'd30};
        tbl[5] = '{1'b0, 5'd13, 6'd45, 24'h014500, 6'b100000, 1'b1, 5'd13, 6'd45};
        tbl[6] = '{1'b1, 5'd24, 6'd10, 24'h134500, 6'b000000, 1'b1, 5'd13, 6'd45};
        tbl[7] = '{1'b1, 5'd10, 6'd60, 24'h134500, 6'b000000, 1'b1, 5'd13, 6'd45};
        tbl[8] = '{1'b1, 5'd23, 6'd59, 24'h235900, 6'b000000, 1'b1, 5'd23, 6'd59};
        tbl[9] = '{1'b0, 5'd1,  6'd0,  24'h010000, 6'b100000, 1'b0, 5'd1,  6'd0};

        // Reset state in both display modes
        exp_push(24'h120000, 6'b0, 1'b0, 2'd0, 1'b1, 5'd0, 6'd0, 6'd0);
        cyc(3);
        reset = 1'b0;
        compare("reset_12h");
        check_prop("reset_prop", 1'b0);
        exp_push(24'h000000, 6'b0, 1'b0, 2'd0, 1'b1, 5'd0, 6'd0, 6'd0);
        mode24 = 1'b1; #1;
        compare("reset_24h");
        mode24 = 1'b0;

        // 240 cycles = 60 ticks
        exp_push(24'h120100, 6'b0, 1'b0, 2'd0, 1'b1, 5'd0, 6'd1, 6'd0);
        cyc(240);
        compare("run_1min_12h");
        exp_push(24'h000100, 6'b0, 1'b0, 2'd0, 1'b1, 5'd0, 6'd1, 6'd0);
        mode24 = 1'b1; #1;
        compare("run_1min_24h");
        mode24 = 1'b0;

        // ext_load vector table, one row per cycle
        for (int i = 0; i < 10; i++) begin
            mode24 = tbl[i].m24;
            exp_push(tbl[i].dig, tbl[i].blk, tbl[i].pm, 2'd0, 1'b1, tbl[i].h, tbl[i].m, 6'd0);
            drive(1'b0, 1'b0, 1'b0, 1'b1, tbl[i].eh, tbl[i].em);
            compare($sformatf("load_row%0d", i));
        end
        mode24 = 1'b0;

        // Day rollover
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd23, 6'd59);
        exp_push(24'h115959, 6'b0, 1'b1, 2'd0, 1'b1, 5'd23, 6'd59, 6'd59);
        cyc(236);
        compare("pre_rollover");
        exp_push(24'h120000, 6'b0, 1'b0, 2'd0, 1'b1, 5'd0, 6'd0, 6'd0);
        cyc(4);
        compare("rollover");

        // Load coinciding with a tick: load wins
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 6'd2);
        cyc(3);
        exp_push(24'h010300, 6'b100000, 1'b0, 2'd0, 1'b1, 5'd1, 6'd3, 6'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 6'd3);
        compare("load_on_tick");
        exp_push(24'h010301, 6'b100000, 1'b0, 2'd0, 1'b1, 5'd1, 6'd3, 6'd1);
        cyc(4);
        compare("tick_after_load");

        // Full set sequence: up x13, down x1, up x5, commit
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        pulsed_up = 1'b1; cyc(13); pulsed_up = 1'b0;
        exp_push(24'h010000, 6'b100000, 1'b1, 2'd1, 1'b0, 5'd0, 6'd0, 6'd0);
        compare("set_hr_13");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
        exp_push(24'h015900, 6'b100000, 1'b1, 2'd2, 1'b0, 5'd0, 6'd0, 6'd0);
        compare("set_min_wrap_down");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        pulsed_up = 1'b1; cyc(5); pulsed_up = 1'b0;
        exp_push(24'h015905, 6'b100000, 1'b1, 2'd3, 1'b0, 5'd0, 6'd0, 6'd0);
        compare("set_sec_5");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        exp_push(24'h015905, 6'b100000, 1'b1, 2'd0, 1'b1, 5'd13, 6'd59, 6'd5);
        compare("commit");
        check_prop("commit_prop_high", 1'b1);
        cyc(1);
        check_prop("commit_prop_low", 1'b0);
        exp_push(24'h015905, 6'b100000, 1'b1, 2'd0, 1'b1, 5'd13, 6'd59, 6'd5);
        compare("after_commit");

        // In SET_MIN: load ignored, up, up+down, gated up, set+up
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        exp_push(24'h120000, 6'b0, 1'b0, 2'd2, 1'b1, 5'd0, 6'd0, 6'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 6'd7);
        compare("load_in_set_ignored");
        exp_push(24'h120100, 6'b0, 1'b0, 2'd2, 1'b1, 5'd0, 6'd0, 6'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
        compare("set_min_up");
        exp_push(24'h120100, 6'b0, 1'b0, 2'd2, 1'b1, 5'd0, 6'd0, 6'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 6'd0);
        compare("up_down_same_cycle");
        set_enable = 1'b0;
        exp_push(24'h120100, 6'b0, 1'b0, 2'd2, 1'b1, 5'd0, 6'd0, 6'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
        compare("set_enable_low");
        set_enable = 1'b1;
        exp_push(24'h120100, 6'b0, 1'b0, 2'd3, 1'b0, 5'd0, 6'd0, 6'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
        compare("set_wins_over_up");
        exp_push(24'h120159, 6'b0, 1'b0, 2'd3, 1'b0, 5'd0, 6'd0, 6'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
        compare("sec_wrap_down");
        reset = 1'b1;
        exp_push(24'h120000, 6'b0, 1'b0, 2'd0, 1'b1, 5'd0, 6'd0, 6'd0);
        cyc(1);
        compare("reset_mid_set");
        check_prop("reset_mid_set_prop", 1'b0);
        reset = 1'b0;
        cyc(1);
        check_prop("reset_mid_set_prop2", 1'b0);

        // Hour wrap and blink boundary
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        exp_push(24'h110000, 6'b0, 1'b1, 2'd1, 1'b0, 5'd0, 6'd0, 6'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
        compare("hr_wrap_down");
        exp_push(24'h120000, 6'b0, 1'b0, 2'd1, 1'b0, 5'd0, 6'd0, 6'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
        compare("hr_wrap_up");
        pulsed_up = 1'b1; pulsed_down = 1'b1;
        exp_push(24'h120000, 6'b0, 1'b0, 2'd1, 1'b0, 5'd0, 6'd0, 6'd0);
        cyc(29);
        compare("blink_before_toggle");
        exp_push(24'h120000, 6'b110000, 1'b0, 2'd1, 1'b0, 5'd0, 6'd0, 6'd0);
        cyc(1);
        compare("blink_hr_blanked");
        pulsed_up = 1'b0; pulsed_down = 1'b0;
        exp_push(24'h120000, 6'b0, 1'b0, 2'd2, 1'b0, 5'd0, 6'd0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        compare("blink_reset_on_transition");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);

        // Load coinciding with set in RUN
        exp_push(24'h070800, 6'b100000, 1'b0, 2'd1, 1'b1, 5'd7, 6'd8, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 6'd8);
        compare("load_with_set");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 6'd4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
`ifdef SETCLK_TIMEOUT_EN
        exp_push(24'h040400, 6'b100000, 1'b0, 2'd1, 1'b1, 5'd4, 6'd4, 6'd3);
        cyc(11);
        compare("timeout_not_yet");
        exp_push(24'h040403, 6'b100000, 1'b0, 2'd0, 1'b1, 5'd4, 6'd4, 6'd3);
        cyc(1);
        compare("timeout_exit");
        check_prop("timeout_no_prop", 1'b0);
        cyc(1);
        check_prop("timeout_no_prop2", 1'b0);
`else
        exp_push(24'h040400, 6'b110000, 1'b0, 2'd1, 1'b0, 5'd0, 6'd0, 6'd0);
        cyc(40);
        compare("set_persists");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        check_prop("persist_exit_prop", 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
